reg_file: RTL

Architectural register file with per-register rename status for the out-of-order core. It sits between the issue stage and the reorder buffer. At issue it marks a destination register as pending on a ROB tag taken from the ROB's next-entry output. At commit it consumes the ROB's retirement stream, writes the value and releases the rename when the tag still matches. Two combinational source-lookup ports give the issuing instruction either a ready value or the ROB tag to wait on.

---
 rtl/reg_file_if.sv | 38 +++
 rtl/reg_file.sv | 79 +++++++
 2 files changed

// File: rtl/reg_file_if.sv
// Issue/commit/lookup bundle between the issue stage, ROB and reg_file.
// master drives issue, commit, flush and lookup indices; slave returns lookups.
interface reg_file_if #(
   parameter int ROB_LOG = 4
) ();
   logic               issue_valid;
   logic [4:0]         issue_rd;
   logic [ROB_LOG-1:0] issue_tag;
   logic               commit_valid;
   logic [4:0]         commit_rd;
   logic [ROB_LOG-1:0] commit_tag;
   logic [31:0]        commit_value;
   logic               flush;
   logic [4:0]         rs1;
   logic [4:0]         rs2;
   logic [31:0]        rs1_val;
   logic               rs1_busy;
   logic [ROB_LOG-1:0] rs1_tag;
   logic [31:0]        rs2_val;
   logic               rs2_busy;
   logic [ROB_LOG-1:0] rs2_tag;

   modport master (
      output issue_valid, issue_rd, issue_tag,
      output commit_valid, commit_rd, commit_tag,
      output commit_value, flush, rs1, rs2,
      input  rs1_val, rs1_busy, rs1_tag,
      input  rs2_val, rs2_busy, rs2_tag
   );

   modport slave (
      input  issue_valid, issue_rd, issue_tag,
      input  commit_valid, commit_rd, commit_tag,
      input  commit_value, flush, rs1, rs2,
      output rs1_val, rs1_busy, rs1_tag,
      output rs2_val, rs2_busy, rs2_tag
   );
endinterface

// File: rtl/reg_file.sv
// Architectural register file with per-register ROB rename status.
// Ports: clk, rst (sync, active-high), rdy (global enable), bus (slave).
module reg_file #(
   parameter int ROB_LOG = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rdy,
   reg_file_if.slave  bus
);
   localparam int LW = 33 + ROB_LOG;

   logic [31:0]        value_q [32];
   logic               busy_q  [32];
   logic [ROB_LOG-1:0] tag_q   [32];

   logic cm_ok;
   logic is_ok;

   assign cm_ok = bus.commit_valid && (bus.commit_rd != 5'd0);
   assign is_ok = bus.issue_valid && (bus.issue_rd != 5'd0)
                  && !bus.flush;

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 32; i++) begin
            value_q[i] <= '0;
            busy_q[i]  <= 1'b0;
            tag_q[i]   <= '0;
         end
      end else if (rdy) begin
         for (int i = 1; i < 32; i++) begin
            if (cm_ok && bus.commit_rd == 5'(i))
               value_q[i] <= bus.commit_value;
            if (bus.flush) begin
               busy_q[i] <= 1'b0;
               tag_q[i]  <= '0;
            end else if (is_ok && bus.issue_rd == 5'(i)) begin
               // issue overrides any same-cycle release
               busy_q[i] <= 1'b1;
               tag_q[i]  <= bus.issue_tag;
            end else if (cm_ok && bus.commit_rd == 5'(i)
                         && busy_q[i]
                         && tag_q[i] == bus.commit_tag) begin
               busy_q[i] <= 1'b0;
            end
         end
      end
   end

   // {val, busy, tag}; commit bypass ignores same-cycle issue
   function automatic logic [LW-1:0] lookup(input logic [4:0] rs);
      logic [LW-1:0] r;
      r = '0;
      if (rs == 5'd0) begin
         r = '0;
      end else if (bus.commit_valid && bus.commit_rd == rs
                   && busy_q[rs]
                   && tag_q[rs] == bus.commit_tag) begin
         r = {bus.commit_value, 1'b0, {ROB_LOG{1'b0}}};
      end else if (busy_q[rs]) begin
         r = {value_q[rs], 1'b1, tag_q[rs]};
      end else begin
         r = {value_q[rs], 1'b0, {ROB_LOG{1'b0}}};
      end
      return r;
   endfunction

   logic [LW-1:0] l1;
   logic [LW-1:0] l2;

   always_comb begin
      l1 = lookup(bus.rs1);
      l2 = lookup(bus.rs2);
   end

   assign {bus.rs1_val, bus.rs1_busy, bus.rs1_tag} = l1;
   assign {bus.rs2_val, bus.rs2_busy, bus.rs2_tag} = l2;
endmodule
